// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - turn/commit sequencer between player buttons and the win checker
// Asynchronous active-low reset on rst; B, game_over and state decode directly from the FSM register.
module turn_sequencer #(
  parameter int NUM_PLAYERS = 4,
  parameter int NUM_CARDS   = 12,
  parameter int GOAL_POS    = 23,
  parameter int WAIT_CYC    = 2,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_flip,
  input  logic [4:0] card_sw,
  input  logic       W,
  input  logic [4:0] pos_in,
  output logic [1:0] T,
  output logic [4:0] N,
  output logic       B,
  output logic       card_err,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_EVAL   = 3'd4,
    S_DONE   = 3'd5
  } st_t;

  st_t         cur_st, nxt_st;
  logic        btn_q, armed, flip_rise;
  logic [31:0] to_cnt, to_cnt_nxt;
  logic [3:0]  w_cnt, w_cnt_nxt;
  logic [1:0]  t_nxt, t_adv, winner_nxt;
  logic [4:0]  n_nxt;
  logic        err_nxt, card_ok;

  // armed stays low after reset until the button is seen released, so a held button cannot fire
  assign flip_rise = btn_flip & ~btn_q & armed;
  assign t_adv     = (T == 2'(NUM_PLAYERS - 1)) ? 2'd0 : T + 2'd1;
  assign card_ok   = {27'd0, card_sw} < 32'(NUM_CARDS);

  always_comb begin
    nxt_st     = cur_st;
    t_nxt      = T;
    n_nxt      = N;
    winner_nxt = winner;
    to_cnt_nxt = '0;
    w_cnt_nxt  = '0;
    err_nxt    = 1'b0;
    case (cur_st)
      S_IDLE: begin
        t_nxt      = 2'd0;
        winner_nxt = 2'd0;
        if (flip_rise) nxt_st = S_SELECT;
      end
      S_SELECT: begin
        to_cnt_nxt = to_cnt + 32'd1;
        if (flip_rise) begin
          to_cnt_nxt = '0;
          if (card_ok) begin
            n_nxt  = card_sw;
            nxt_st = S_ISSUE;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (to_cnt == 32'(TIMEOUT_CYC - 1)) begin
          t_nxt      = t_adv;
          to_cnt_nxt = '0;
        end
      end
      S_ISSUE: nxt_st = S_WAIT;
      S_WAIT: begin
        if (w_cnt == 4'(WAIT_CYC - 1)) nxt_st = S_EVAL;
        else w_cnt_nxt = w_cnt + 4'd1;
      end
      S_EVAL: begin
        nxt_st = S_SELECT;
        if (W && (pos_in == 5'(GOAL_POS))) begin
          nxt_st     = S_DONE;
          winner_nxt = T;
        end else if (!W) begin
          t_nxt = t_adv;
        end
      end
      S_DONE: begin
        if (flip_rise) begin
          nxt_st     = S_IDLE;
          t_nxt      = 2'd0;
          winner_nxt = 2'd0;
        end
      end
      default: nxt_st = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_st   <= S_IDLE;
      btn_q    <= 1'b0;
      armed    <= 1'b0;
      to_cnt   <= '0;
      w_cnt    <= '0;
      T        <= 2'd0;
      N        <= 5'd0;
      winner   <= 2'd0;
      card_err <= 1'b0;
    end else begin
      cur_st   <= nxt_st;
      btn_q    <= btn_flip;
      if (!btn_flip) armed <= 1'b1;
      to_cnt   <= to_cnt_nxt;
      w_cnt    <= w_cnt_nxt;
      T        <= t_nxt;
      N        <= n_nxt;
      winner   <= winner_nxt;
      card_err <= err_nxt;
    end
  end

  assign B         = (cur_st == S_ISSUE);
  assign game_over = (cur_st == S_DONE);
  assign state     = cur_st;

endmodule

// File: doc/turn_sequencer.md
TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide NUM_PLAYERS, 4, active players (2..4); T counts 0..NUM_PLAYERS-1.
REQ-002 SHALL provide NUM_CARDS, 12, valid card indices 0..NUM_CARDS-1 (max 32).
REQ-003 SHALL provide GOAL_POS, 23, checker position value that ends the game.
REQ-004 SHALL provide WAIT_CYC, 2, cycles from B pulse to sampling W/pos_in (1..15).
REQ-005 SHALL provide TIMEOUT_CYC, 50000000, SELECT cycles before the turn is forfeited (fits 32 bits).
Ports (name, direction, width, meaning):
REQ-006 SHALL provide clk, input, 1, single clock; all state on rising edge.
REQ-007 SHALL provide rst, input, 1; reset is asynchronous and active-low.
REQ-008 SHALL provide btn_flip, input, 1, debounced level of the flip/commit button.
REQ-009 SHALL provide card_sw, input, 5, card index chosen by the current player.
REQ-010 SHALL provide W, input, 1, match result from the win checker.
REQ-011 SHALL provide pos_in, input, 5, post-move position from the win checker.
REQ-012 SHALL provide T, output, 2, current player.
REQ-013 SHALL provide N, output, 5, latched card index driven to the checker.
REQ-014 SHALL provide B, output, 1, one-cycle commit strobe to the checker.
REQ-015 SHALL provide card_err, output, 1, one-cycle pulse on an invalid card index.
REQ-016 SHALL provide game_over, output, 1, high while in DONE.
REQ-017 SHALL provide winner, output, 2, valid while game_over is high.
REQ-018 SHALL provide state, output, 3, FSM state code for display/debug.

Function
REQ-019 SHALL detect flip_rise = btn_flip high this cycle and low the previous cycle (one registered delay); a held button yields exactly one flip_rise.
REQ-020 SHALL implement states IDLE=0, SELECT=1, ISSUE=2, WAIT=3, EVAL=4, DONE=5; codes 6-7 return to IDLE on the next clock.
REQ-021 IDLE: T=0; flip_rise -> SELECT, timeout counter cleared.
REQ-022 SELECT: on flip_rise with card_sw < NUM_CARDS, latch N=card_sw and go to ISSUE; with card_sw >= NUM_CARDS, pulse card_err one cycle, N unchanged, stay in SELECT, timeout counter cleared.
REQ-023 SELECT: timeout counter increments each cycle; at TIMEOUT_CYC-1 without flip_rise, T advances (wraps NUM_PLAYERS-1 -> 0), counter clears, stay in SELECT; flip_rise in that same cycle takes priority (no forfeit).
REQ-024 ISSUE: B=1 for exactly this one cycle, then WAIT; B SHALL be 0 in every other state.
REQ-025 WAIT: count WAIT_CYC cycles after the ISSUE cycle, then EVAL; btn_flip ignored (edge detector still tracks).
REQ-026 EVAL (one cycle): W=1 and pos_in==GOAL_POS -> DONE, winner=T; W=1 otherwise -> SELECT, same T; W=0 -> SELECT, T advances with wrap.
REQ-027 N SHALL hold its value from latch until the next valid latch; T SHALL change only in IDLE, SELECT forfeit, EVAL, and restart.
REQ-028 DONE: game_over=1, winner and T frozen; flip_rise -> IDLE with T=0, winner=0, game_over=0 on the following cycle.

Reset
REQ-029 rst low SHALL immediately force state=IDLE, T=0, N=0, B=0, card_err=0, game_over=0, winner=0, counters and edge-detect register 0, including mid-WAIT (no B re-issue after release).
REQ-030 After rst rises, a button already held SHALL NOT produce flip_rise until released and pressed again.

Verification
REQ-031 Reset, flip, card_sw=7, flip -> N=7, B high exactly one cycle, EVAL WAIT_CYC+1 cycles after B; W=0 -> T 0->1.
REQ-032 T=3, W=0 at EVAL -> T=0 (wrap); W=1, pos_in=10 -> T unchanged, state=SELECT.
REQ-033 T=2, W=1, pos_in=23 -> game_over=1, winner=2, state=5; next flip -> state=0, T=0, game_over=0.
REQ-034 SELECT, card_sw=15, flip -> card_err one-cycle pulse, no B, state stays 1, N unchanged.
REQ-035 TIMEOUT_CYC=10, no flip in SELECT -> T advances after exactly 10 cycles; flip on cycle 10 -> ISSUE, no forfeit.
REQ-036 rst asserted during WAIT -> all outputs 0 asynchronously; button held across release -> no B until re-press.
